pack_arbiter: RTL and testbench
===============================

# pack_arbiter

Round-robin scheduler that shares one packing datapath between `N_REQ` word-wide requesters. Each cycle it grants at most one requester, places the accepted word into the next slot of a concatenation register, and presents the full `N_PACK`-word concatenation downstream with a valid/ready handshake. It sits between independent narrow producers and a single wide consumer, for example a bus-width adapter or a packet assembler.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `WORD_W`, default 8: width of each requester word.
- `N_PACK`, default 4: words per output beat, ≥2.
- `i_clk` input 1: clock.
- `i_rst` input 1: reset. Asynchronous, active-high.
- `i_cg` input 1: clock-gate enable. When 0, all state holds and every ready and valid output is 0.
- `i_reqValid` input N_REQ: per-requester valid.
- `o_reqReady` output N_REQ: per-requester ready. One-hot or zero.
- `i_reqData` input N_REQ*WORD_W: requester r occupies bits [r*WORD_W +: WORD_W].
- `i_flush` input 1: emit a partially filled beat.
- `o_outValid` output 1: output beat valid.
- `i_outReady` input 1: consumer ready.
- `o_outData` output N_PACK*WORD_W: packed beat. The first-accepted word is in the most-significant slot.
- `o_outFill` output $clog2(N_PACK+1): number of valid words in the beat, 1..N_PACK when valid.

## Operation
- States:
  - FILL: accepting words; `o_outValid`=0.
  - FULL: beat held; `o_outValid`=1.
- Slot counter `fill`, 0..N_PACK. An accepted word is written to slot index N_PACK-1-fill, then `fill` increments.
- Arbitration: `ptr` holds the last granted index. Priority is searched from (ptr+1) mod N_REQ upward with wrap, and the first valid requester wins.
  - `o_reqReady` is the one-hot grant, qualified by an accept window: (state==FILL) or (state==FULL and `i_outReady`).
  - `ptr` updates only on an accepted transfer (valid & ready).
  - An idle requester never blocks others. A continuously valid requester gets at most one word per N_REQ accepted words when all requesters are valid.
- FILL transitions:
  - An accept that makes `fill`==N_PACK moves to FULL.
  - `i_flush` with `fill`>0 moves to FULL without writing further words. Unfilled slots read 0. `o_outFill`=fill.
  - `i_flush` with `fill`==0 is ignored.
  - If an accept and `i_flush` occur in the same cycle, the word is accepted first, then the beat is flushed.
- FULL transitions:
  - An output handshake (`o_outValid` & `i_outReady`) clears the beat.
  - A word accepted in the same cycle lands in the most-significant slot with `fill`=1, and the state goes to FILL. This sustains one word per cycle.
  - With no accept, `fill`=0 and the state goes to FILL.
  - `i_flush` in FULL is ignored.
- Unused slots are zeroed when a new beat starts.

## Timing
- Reset values: state FILL, `fill`=0, `ptr`=N_REQ-1 (requester 0 has first priority), `o_outValid`=0, `o_outData`=0, `o_outFill`=0. `o_reqReady` is forced to 0 while `i_rst`=1.
- Latency: a word accepted at cycle t is visible in `o_outData` from t+1. The beat-completing word accepted at t gives `o_outValid`=1 at t+1.
- Combinational paths:
  - `i_reqValid` → `o_reqReady`.
  - `i_outReady` → `o_reqReady`.
  - No combinational path from `i_reqData` to any output.
- `o_outValid`, `o_outData` and `o_outFill` are registered and stable while `o_outValid`=1 and `i_outReady`=0.
- Reset asserted mid-beat discards the partial beat immediately (asynchronously).

## Configuration
- `PACK_ARBITER_SRC_EN`:
  - Defined: adds output `o_outSrc` of width N_PACK*$clog2(N_REQ). It records the requester index per slot in the same slot order as `o_outData`. Unfilled slots read 0. It resets to 0.
  - Undefined: the port and its registers are absent. All other behaviour is identical.

## Structure
- `pack_arbiter_pkg`:
  - State enum.
  - `function` computing slot bit offsets.
  - Localparams for the `$clog2` widths.
- Sub-module `rr_arbiter`: purely combinational. Inputs are the request vector and `ptr`; output is a one-hot grant. It is reusable elsewhere.
- The top level holds the FSM, `fill`, `ptr`, the data and source registers, and the flush handling.

## Test plan
- Defaults; requester 0 alone sends 0x11,0x22,0x33,0x44; `i_outReady`=1 → one beat `o_outData`=0x11223344, `o_outFill`=4, then FILL.
- All four valid continuously; requester r sends 0xr0+n → grants in order 0,1,2,3,0,…; first beat 0x00102030; no requester is granted twice within 4 accepts.
- Beat full with `i_outReady`=0 for 5 cycles → `o_reqReady`=0 and `o_outData` stable. Then `i_outReady`=1 with a requester valid → handshake and accept in the same cycle; next beat has `fill`=1.
- Two words 0xAA,0xBB, then `i_flush` → `o_outData`=0xAABB0000, `o_outFill`=2. `i_flush` at `fill`==0 → no `o_outValid`.
- Reset asserted at `fill`=3 → outputs 0 immediately; after release, requester 0 has priority.
- With `PACK_ARBITER_SRC_EN`, scenario 2 → `o_outSrc` = {0,1,2,3} (2 bits per slot, 0x1B).

Source files
------------

// File: rtl/pack_arbiter_pkg.sv
// pack_arbiter_pkg: shared types, default sizes and slot helpers for the
// pack_arbiter round-robin packer and its rr_arbiter sub-module.
package pack_arbiter_pkg;

  // Beat assembly state: FILL accepts words, FULL holds a beat for the consumer.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // Default configuration and the widths derived from it.
  localparam int DEF_N_REQ  = 4;
  localparam int DEF_WORD_W = 8;
  localparam int DEF_N_PACK = 4;
  localparam int DEF_PTR_W  = $clog2(DEF_N_REQ);
  localparam int DEF_FILL_W = $clog2(DEF_N_PACK + 1);

  // Low bit of a slot inside a packed vector of equally sized fields.
  function automatic int slot_lo(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. Searches from ptr+1 upward
// with wrap and grants the first active request (one-hot, or zero if none).
module rr_arbiter
  import pack_arbiter_pkg::*;
#(
  parameter int N     = DEF_N_REQ,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [PTR_W-1:0] cand;

  // Walk the candidates in priority order starting just after the last winner.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pack_arbiter.sv
// pack_arbiter: shares one packing register between N_REQ word-wide
// requesters. Accepted words fill slots MSB-first; a full (or flushed) beat
// is offered downstream with valid/ready. Optional feature macro
// PACK_ARBITER_SRC_EN adds o_outSrc, the requester index recorded per slot.
module pack_arbiter
  import pack_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int WORD_W = DEF_WORD_W,
  parameter int N_PACK = DEF_N_PACK
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_cg,
  input  logic [N_REQ-1:0]                  i_reqValid,
  output logic [N_REQ-1:0]                  o_reqReady,
  input  logic [N_REQ*WORD_W-1:0]           i_reqData,
  input  logic                              i_flush,
  output logic                              o_outValid,
  input  logic                              i_outReady,
  output logic [N_PACK*WORD_W-1:0]          o_outData,
`ifdef PACK_ARBITER_SRC_EN
  output logic [N_PACK*$clog2(N_REQ)-1:0]   o_outSrc,
`endif
  output logic [$clog2(N_PACK+1)-1:0]       o_outFill
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int FILL_W = $clog2(N_PACK + 1);
  localparam int DATA_W = N_PACK * WORD_W;

  state_e              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
`ifdef PACK_ARBITER_SRC_EN
  localparam int SRC_W = N_PACK * PTR_W;
  logic [SRC_W-1:0]    src_q, src_d;
`endif

  logic [N_REQ-1:0]    grant;
  logic [PTR_W-1:0]    grant_idx;
  logic [WORD_W-1:0]   word;
  logic                accept_win;
  logic                accept;
  logic [FILL_W-1:0]   wr_slot;
  logic [FILL_W-1:0]   fill_inc;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (i_reqValid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // A word may enter while filling, or while full if the held beat leaves this cycle.
  assign accept_win = (state_q == ST_FILL) || i_outReady;
  assign o_reqReady = (i_cg && !i_rst && accept_win) ? grant : '0;
  assign accept     = |o_reqReady;
  assign wr_slot    = FILL_W'(N_PACK - 1) - fill_q;
  assign fill_inc   = fill_q + FILL_W'(1);

  // Encode the one-hot grant and select the granted word.
  always_comb begin
    grant_idx = '0;
    word      = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant[r]) begin
        grant_idx = PTR_W'(r);
        word      = i_reqData[slot_lo(r, WORD_W) +: WORD_W];
      end
    end
  end

  // Next-state logic: slot writes, fill count, pointer and beat transitions.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
`ifdef PACK_ARBITER_SRC_EN
    src_d   = src_q;
`endif
    if (i_cg) begin
      if (accept) ptr_d = grant_idx;
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            for (int s = 0; s < N_PACK; s++) begin
              if (FILL_W'(s) == wr_slot) begin
                data_d[slot_lo(s, WORD_W) +: WORD_W] = word;
`ifdef PACK_ARBITER_SRC_EN
                src_d[slot_lo(s, PTR_W) +: PTR_W] = grant_idx;
`endif
              end
            end
            fill_d = fill_inc;
            // The word lands first; a same-cycle flush then closes the beat.
            if (fill_inc == FILL_W'(N_PACK) || i_flush) state_d = ST_FULL;
          end else if (i_flush && fill_q != '0) begin
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          // Handshake clears the beat; a word accepted alongside opens the next one.
          if (i_outReady) begin
            state_d = ST_FILL;
            data_d  = '0;
            fill_d  = '0;
`ifdef PACK_ARBITER_SRC_EN
            src_d   = '0;
`endif
            if (accept) begin
              data_d[slot_lo(N_PACK - 1, WORD_W) +: WORD_W] = word;
              fill_d = FILL_W'(1);
`ifdef PACK_ARBITER_SRC_EN
              src_d[slot_lo(N_PACK - 1, PTR_W) +: PTR_W] = grant_idx;
`endif
            end
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  // State registers with asynchronous reset discarding any partial beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      // NOTE: the packing register is a handful of flops, not a RAM, so it is reset to give zeroed slots.
      data_q  <= '0;
`ifdef PACK_ARBITER_SRC_EN
      src_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
`ifdef PACK_ARBITER_SRC_EN
      src_q   <= src_d;
`endif
    end
  end

  assign o_outValid = i_cg && (state_q == ST_FULL);
  assign o_outData  = data_q;
  assign o_outFill  = fill_q;
`ifdef PACK_ARBITER_SRC_EN
  assign o_outSrc   = src_q;
`endif

endmodule

// File: tb/tb_pack_arbiter.sv
// tb_pack_arbiter: table-driven vectors, hand-written multi-cycle sequences
// and a randomized run against a queue-based model for pack_arbiter.
module tb_pack_arbiter;
  import pack_arbiter_pkg::*;

  localparam int NR = DEF_N_REQ;
  localparam int W  = DEF_WORD_W;
  localparam int NP = DEF_N_PACK;
  localparam int FW = DEF_FILL_W;
  localparam int PW = DEF_PTR_W;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_cg;
  logic [NR-1:0]     i_reqValid;
  logic [NR-1:0]     o_reqReady;
  logic [NR*W-1:0]   i_reqData;
  logic              i_flush;
  logic              o_outValid;
  logic              i_outReady;
  logic [NP*W-1:0]   o_outData;
  logic [FW-1:0]     o_outFill;
`ifdef PACK_ARBITER_SRC_EN
  logic [NP*PW-1:0]  o_outSrc;
`endif

  always #5 clk = ~clk;

  pack_arbiter #(.N_REQ(NR), .WORD_W(W), .N_PACK(NP)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_cg       (i_cg),
    .i_reqValid (i_reqValid),
    .o_reqReady (o_reqReady),
    .i_reqData  (i_reqData),
    .i_flush    (i_flush),
    .o_outValid (o_outValid),
    .i_outReady (i_outReady),
    .o_outData  (o_outData),
`ifdef PACK_ARBITER_SRC_EN
    .o_outSrc   (o_outSrc),
`endif
    .o_outFill  (o_outFill)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR*W-1:0] d,
                       input logic fl, input logic ordy);
    i_reqValid = v;
    i_reqData  = d;
    i_flush    = fl;
    i_outReady = ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    i_cg  = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NR-1:0]   valid;
    logic [NR*W-1:0] data;
    logic            flush;
    logic            out_rdy;
    logic [NR-1:0]   e_ready;
    logic            e_valid;
    logic [NP*W-1:0] e_data;
    logic [FW-1:0]   e_fill;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic fl,
                              input logic ordy, input logic [3:0] er, input logic ev,
                              input logic [31:0] ed, input logic [2:0] ef);
    vec_t t;
    t.valid = v; t.data = d; t.flush = fl; t.out_rdy = ordy;
    t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_fill = ef;
    return t;
  endfunction

  vec_t tbl [13];

  // ---------------- reference model ----------------
  int              m_ptr;
  bit              m_full;
  logic [W-1:0]    m_q [$];

  function automatic logic [NR-1:0] m_ready(input logic [NR-1:0] v, input logic cg, input logic ordy);
    if (!cg || (m_full && !ordy)) return '0;
    for (int k = 1; k <= NR; k++) begin
      int r;
      r = (m_ptr + k) % NR;
      if (v[r]) return NR'(1) << r;
    end
    return '0;
  endfunction

  function automatic logic [NP*W-1:0] m_data();
    logic [NP*W-1:0] acc;
    acc = '0;
    for (int k = 0; k < m_q.size(); k++)
      acc = acc | ({{(NP*W-W){1'b0}}, m_q[k]} << ((NP - 1 - k) * W));
    return acc;
  endfunction

  task automatic m_step(input logic [NR-1:0] v, input logic [NR*W-1:0] d,
                        input logic fl, input logic ordy, input logic cg);
    logic [NR-1:0] g;
    bit            was_full;
    if (cg) begin
      g        = m_ready(v, cg, ordy);
      was_full = m_full;
      if (was_full && ordy) begin
        m_q.delete();
        m_full = 1'b0;
      end
      for (int r = 0; r < NR; r++) begin
        if (g[r]) begin
          m_q.push_back(d[r*W +: W]);
          m_ptr = r;
        end
      end
      if (m_q.size() == NP) m_full = 1'b1;
      else if (!was_full && fl && m_q.size() > 0) m_full = 1'b1;
    end
  endtask

  initial begin
    int n [NR];
    logic [NP*W-1:0] held;
    logic [NR-1:0]   rv;
    logic [NR*W-1:0] rd;
    logic            rfl, rordy, rcg;

    // Reset state, with requests present to prove ready is forced low.
    i_rst = 1'b1;
    i_cg  = 1'b1;
    drive('1, '0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", o_reqReady, 0);
    check("rst_valid", o_outValid, 0);
    check("rst_data",  o_outData, 0);
    check("rst_fill",  o_outFill, 0);
    i_rst = 1'b0;
    drive('0, '0, 1'b0, 1'b0);

    // Table: single requester beat, then a flushed partial beat and an ignored flush.
    tbl[0]  = mk(4'b0001, 32'h0000_0011, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h0000_0000, 3'd0);
    tbl[1]  = mk(4'b0001, 32'h0000_0022, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h1100_0000, 3'd1);
    tbl[2]  = mk(4'b0001, 32'h0000_0033, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h1122_0000, 3'd2);
    tbl[3]  = mk(4'b0001, 32'h0000_0044, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h1122_3300, 3'd3);
    tbl[4]  = mk(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'h1122_3344, 3'd4);
    tbl[5]  = mk(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0000_0000, 3'd0);
    tbl[6]  = mk(4'b0010, 32'h0000_AA00, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h0000_0000, 3'd0);
    tbl[7]  = mk(4'b0010, 32'h0000_BB00, 1'b0, 1'b1, 4'b0010, 1'b0, 32'hAA00_0000, 3'd1);
    tbl[8]  = mk(4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'hAABB_0000, 3'd2);
    tbl[9]  = mk(4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hAABB_0000, 3'd2);
    tbl[10] = mk(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'hAABB_0000, 3'd2);
    tbl[11] = mk(4'b0000, 32'h0000_0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0000_0000, 3'd0);
    tbl[12] = mk(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0000_0000, 3'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].valid, tbl[i].data, tbl[i].flush, tbl[i].out_rdy);
      #1;
      check($sformatf("vec%0d_ready", i), o_reqReady, tbl[i].e_ready);
      check($sformatf("vec%0d_valid", i), o_outValid, tbl[i].e_valid);
      check($sformatf("vec%0d_data", i),  o_outData,  tbl[i].e_data);
      check($sformatf("vec%0d_fill", i),  o_outFill,  tbl[i].e_fill);
    end

    // All requesters valid: strict rotation, one word per cycle across beats.
    do_reset();
    for (int r = 0; r < NR; r++) n[r] = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive('1, '0, 1'b0, 1'b1);
      for (int r = 0; r < NR; r++) i_reqData[r*W +: W] = W'((r << 4) + n[r]);
      #1;
      check($sformatf("rot_grant_c%0d", c), o_reqReady, 64'(1) << (c % NR));
      check($sformatf("rot_valid_c%0d", c), o_outValid, (c == 4 || c == 8) ? 1 : 0);
      if (c == 4) begin
        check("rot_beat0", o_outData, 32'h0010_2030);
`ifdef PACK_ARBITER_SRC_EN
        check("rot_src0", o_outSrc, 8'h1B);
`endif
      end
      if (c == 8) begin
        check("rot_beat1", o_outData, 32'h0111_2131);
`ifdef PACK_ARBITER_SRC_EN
        check("rot_src1", o_outSrc, 8'h1B);
`endif
      end
      n[c % NR]++;
    end

    // Back-pressure: held beat blocks all requesters, then handshake plus accept.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(4'b0100, 32'(32'hC0 + c) << 16, 1'b0, 1'b1);
      #1;
      check($sformatf("bp_fill_ready%0d", c), o_reqReady, 4'b0100);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(4'b0001, 32'h0000_005A, 1'b0, 1'b0);
      #1;
      check($sformatf("bp_hold_ready%0d", c), o_reqReady, 0);
      check($sformatf("bp_hold_valid%0d", c), o_outValid, 1);
      check($sformatf("bp_hold_data%0d", c),  o_outData, 32'hC0C1_C2C3);
    end
    @(negedge clk);
    drive(4'b0001, 32'h0000_005A, 1'b0, 1'b1);
    #1;
    check("bp_release_ready", o_reqReady, 4'b0001);
    check("bp_release_valid", o_outValid, 1);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b1);
    #1;
    check("bp_next_valid", o_outValid, 0);
    check("bp_next_fill",  o_outFill, 1);
    check("bp_next_data",  o_outData, 32'h5A00_0000);

    // Clock gate: a full beat is hidden and frozen while i_cg is low.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(4'b0010, 32'(8'h60 + c) << 8, 1'b0, 1'b0);
    end
    @(negedge clk);
    i_cg = 1'b0;
    drive('1, '0, 1'b0, 1'b1);
    #1;
    check("cg_ready", o_reqReady, 0);
    check("cg_valid", o_outValid, 0);
    @(negedge clk);
    i_cg = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    #1;
    check("cg_resume_valid", o_outValid, 1);
    check("cg_resume_data",  o_outData, 32'h6061_6263);

    // Reset mid-beat clears outputs without a clock edge; requester 0 then leads.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(4'b1000, 32'(8'h70 + c) << 24, 1'b0, 1'b1);
      #1;
      check($sformatf("mr_ready%0d", c), o_reqReady, 4'b1000);
    end
    @(negedge clk);
    drive('1, '0, 1'b0, 1'b1);
    #1;
    check("mr_fill_before", o_outFill, 3);
    held = o_outData;
    check("mr_data_before", held, 32'h7071_7200);
    i_rst = 1'b1;
    #1;
    check("mr_data_async",  o_outData, 0);
    check("mr_fill_async",  o_outFill, 0);
    check("mr_ready_async", o_reqReady, 0);
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    check("mr_prio_after", o_reqReady, 4'b0001);

    // Randomized run against the queue model.
    do_reset();
    m_ptr  = NR - 1;
    m_full = 1'b0;
    m_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rv    = NR'($urandom);
      rd    = $urandom;
      rfl   = ($urandom % 6) == 0;
      rordy = ($urandom % 3) != 0;
      rcg   = ($urandom % 8) != 0;
      i_cg  = rcg;
      drive(rv, rd, rfl, rordy);
      #1;
      check("rnd_ready", o_reqReady, m_ready(rv, rcg, rordy));
      check("rnd_valid", o_outValid, rcg && m_full);
      check("rnd_data",  o_outData, m_data());
      check("rnd_fill",  o_outFill, m_q.size());
      m_step(rv, rd, rfl, rordy, rcg);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
